// File: rtl/gray_pkg.sv
// gray_pkg: shared Gray-code helpers for the Gray counter source and the
// downstream Gray-to-binary converter.
//   DEFAULT_GRAY_WIDTH : default counter / Gray bus width
//   GRAY_FN_W          : width the helper functions operate on; callers
//                        zero-extend narrower values and truncate results
//   bin2gray(b)        : b ^ (b >> 1)
//   gray2bin(g)        : prefix XOR running down from the MSB
package gray_pkg;

  localparam int DEFAULT_GRAY_WIDTH = 4;
  localparam int GRAY_FN_W          = 32;

  function automatic logic [GRAY_FN_W-1:0] bin2gray(input logic [GRAY_FN_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero upper bits of a zero-extended input stay zero, so narrow codes
  // convert correctly in the low bits.
  function automatic logic [GRAY_FN_W-1:0] gray2bin(input logic [GRAY_FN_W-1:0] g);
    logic [GRAY_FN_W-1:0] b;
    b[GRAY_FN_W-1] = g[GRAY_FN_W-1];
    for (int i = GRAY_FN_W-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/gray_cnt_src_if.sv
// gray_cnt_src_if: control and output handshake bundle of the Gray counter.
//   master : counter side (drives gray, out_valid, stall, tc)
//   slave  : upstream/downstream side (drives en, up_dn, load, load_bin,
//            out_ready)
// Optional macro GRAY_CNT_SRC_PARITY_EN adds gray_par and step_err.
interface gray_cnt_src_if #(parameter int WIDTH = 4);

  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_bin;
  logic             out_ready;
  logic [WIDTH-1:0] gray;
  logic             out_valid;
  logic             stall;
  logic             tc;
`ifdef GRAY_CNT_SRC_PARITY_EN
  logic             gray_par;
  logic             step_err;

  modport master (input  en, up_dn, load, load_bin, out_ready,
                  output gray, out_valid, stall, tc, gray_par, step_err);
  modport slave  (output en, up_dn, load, load_bin, out_ready,
                  input  gray, out_valid, stall, tc, gray_par, step_err);
`else
  modport master (input  en, up_dn, load, load_bin, out_ready,
                  output gray, out_valid, stall, tc);
  modport slave  (output en, up_dn, load, load_bin, out_ready,
                  input  gray, out_valid, stall, tc);
`endif

endinterface

// File: rtl/gray_cnt_src.sv
// gray_cnt_src: registered Gray-code up/down counter with binary load and a
// valid/ready output handshake. Exactly one gray bit changes per step so the
// bus can be sampled from another clock domain.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   io    : gray_cnt_src_if.master (en, up_dn, load, load_bin, out_ready in;
//           gray, out_valid, stall, tc out)
// Parameters: WIDTH (>= 2), WRAP (1 = modulo wrap, 0 = saturate).
// Optional macro GRAY_CNT_SRC_PARITY_EN adds registered gray_par (XOR of
// gray) and sticky step_err (an accepted step changed != 1 gray bit).
module gray_cnt_src
  import gray_pkg::*;
#(
  parameter int WIDTH = DEFAULT_GRAY_WIDTH,
  parameter int WRAP  = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  gray_cnt_src_if.master io
);

  logic [WIDTH-1:0] bin_q, gray_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] bin_step, gray_step, gray_load;
  logic             free, tc_w, step_ok, do_step;

  assign tc_w    = io.up_dn ? (bin_q == '1) : (bin_q == '0);
  assign free    = ~out_valid_q | io.out_ready;
  // Saturating build: a step off the end is simply not a step.
  assign step_ok = (WRAP != 0) ? 1'b1 : ~tc_w;
  assign do_step = io.en & free & step_ok;

  assign bin_step  = io.up_dn ? bin_q + WIDTH'(1) : bin_q - WIDTH'(1);
  assign gray_step = WIDTH'(bin2gray(GRAY_FN_W'(bin_step)));
  assign gray_load = WIDTH'(bin2gray(GRAY_FN_W'(io.load_bin)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q       <= '0;
      gray_q      <= '0;
      out_valid_q <= 1'b0;
    end else if (io.load) begin
      // Load wins even when stalled; a pending word is dropped.
      bin_q       <= io.load_bin;
      gray_q      <= gray_load;
      out_valid_q <= 1'b1;
    end else if (do_step) begin
      bin_q       <= bin_step;
      gray_q      <= gray_step;
      out_valid_q <= 1'b1;
    end else if (out_valid_q & io.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef GRAY_CNT_SRC_PARITY_EN
  logic gray_par_q, step_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gray_par_q <= 1'b0;
      step_err_q <= 1'b0;
    end else if (io.load) begin
      gray_par_q <= ^gray_load;
    end else if (do_step) begin
      gray_par_q <= ^gray_step;
      if ($countones(gray_q ^ gray_step) != 1) step_err_q <= 1'b1;
    end
  end

  assign io.gray_par = gray_par_q;
  assign io.step_err = step_err_q;
`endif

  assign io.gray      = gray_q;
  assign io.out_valid = out_valid_q;
  assign io.stall     = out_valid_q & ~io.out_ready;
  assign io.tc        = tc_w;

endmodule

// File: tb/tb_gray_cnt_src.sv
// tb_gray_cnt_src: self-checking bench for gray_cnt_src. Two instances share
// the stimulus: u_wrap (WRAP=1) and u_sat (WRAP=0). A behavioural model keeps
// the integer count and valid flag of each instance.
module tb_gray_cnt_src;
  import gray_pkg::*;

  localparam int W   = 4;
  localparam int MAX = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gray_cnt_src_if #(.WIDTH(W)) a ();
  gray_cnt_src_if #(.WIDTH(W)) b ();

  gray_cnt_src #(.WIDTH(W), .WRAP(1)) u_wrap (.clk(clk), .rst_n(rst_n), .io(a.master));
  gray_cnt_src #(.WIDTH(W), .WRAP(0)) u_sat  (.clk(clk), .rst_n(rst_n), .io(b.master));

  logic         en = 1'b0, up_dn = 1'b1, load = 1'b0, out_ready = 1'b0;
  logic [W-1:0] load_bin = '0;

  assign a.en = en;  assign a.up_dn = up_dn;  assign a.load = load;
  assign a.load_bin = load_bin;  assign a.out_ready = out_ready;
  assign b.en = en;  assign b.up_dn = up_dn;  assign b.load = load;
  assign b.load_bin = load_bin;  assign b.out_ready = out_ready;

  int vectors = 0, miscompares = 0;
  int m_cnt [2];
  bit m_vld [2];

  task automatic drive(input logic e, input logic u, input logic l,
                       input logic [W-1:0] lb, input logic r);
    en = e; up_dn = u; load = l; load_bin = lb; out_ready = r;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin m_cnt[i] = 0; m_vld[i] = 1'b0; end
  endtask

  // Advance both models by the rules for one edge, then clock and settle.
  task automatic tick();
    for (int i = 0; i < 2; i++) begin
      bit wrap   = (i == 0);
      bit at_end = up_dn ? (m_cnt[i] == MAX) : (m_cnt[i] == 0);
      if (load) begin
        m_cnt[i] = int'(load_bin); m_vld[i] = 1'b1;
      end else if (en && (!m_vld[i] || out_ready) && (wrap || !at_end)) begin
        m_cnt[i] = (m_cnt[i] + (up_dn ? 1 : MAX)) % (MAX + 1); m_vld[i] = 1'b1;
      end else if (m_vld[i] && out_ready) begin
        m_vld[i] = 1'b0;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; model_reset(); drive(0, 1, 0, '0, 0); #3;
    vectors++; if (a.gray !== 4'b0000) begin miscompares++; $display("FAIL rst_gray got=%b exp=0000", a.gray); end
    vectors++; if (a.out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got=%b exp=0", a.out_valid); end
    vectors++; if (a.stall !== 1'b0) begin miscompares++; $display("FAIL rst_stall got=%b exp=0", a.stall); end
    vectors++; if (a.tc !== 1'b0) begin miscompares++; $display("FAIL rst_tc_up got=%b exp=0", a.tc); end
    up_dn = 1'b0; #1;
    vectors++; if (a.tc !== 1'b1) begin miscompares++; $display("FAIL rst_tc_dn got=%b exp=1", a.tc); end
`ifdef GRAY_CNT_SRC_PARITY_EN
    vectors++; if (a.gray_par !== 1'b0 || a.step_err !== 1'b0) begin miscompares++;
      $display("FAIL rst_par got=%b%b exp=00", a.gray_par, a.step_err); end
`endif
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_count_up();
    logic [W-1:0] exp_g [5] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111};
    drive(1, 1, 0, '0, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++; if (a.gray !== exp_g[i]) begin miscompares++; $display("FAIL up_gray[%0d] got=%b exp=%b", i, a.gray, exp_g[i]); end
      vectors++; if (a.out_valid !== 1'b1) begin miscompares++; $display("FAIL up_valid[%0d] got=%b exp=1", i, a.out_valid); end
      vectors++; if (gray2bin(GRAY_FN_W'(a.gray)) !== GRAY_FN_W'(i + 1)) begin miscompares++;
        $display("FAIL up_bin[%0d] got=%0d exp=%0d", i, gray2bin(GRAY_FN_W'(a.gray)), i + 1); end
    end
  endtask

  task automatic test_wrap();
    drive(0, 1, 1, 4'b1111, 1); tick();
    vectors++; if (a.gray !== 4'b1000) begin miscompares++; $display("FAIL wrap_load got=%b exp=1000", a.gray); end
    vectors++; if (a.tc !== 1'b1) begin miscompares++; $display("FAIL wrap_tc1 got=%b exp=1", a.tc); end
    drive(1, 1, 0, '0, 1); tick();
    vectors++; if (a.gray !== 4'b0000) begin miscompares++; $display("FAIL wrap_step got=%b exp=0000", a.gray); end
    vectors++; if (a.tc !== 1'b0) begin miscompares++; $display("FAIL wrap_tc0 got=%b exp=0", a.tc); end
    // Saturating instance stays parked at all-ones going up.
    vectors++; if (b.gray !== 4'b1000) begin miscompares++; $display("FAIL sat_up got=%b exp=1000", b.gray); end
  endtask

  task automatic test_backpressure();
    drive(0, 1, 1, 4'd2, 1); tick();
    vectors++; if (a.gray !== 4'b0011) begin miscompares++; $display("FAIL bp_start got=%b exp=0011", a.gray); end
    drive(1, 1, 0, '0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (a.gray !== 4'b0011) begin miscompares++; $display("FAIL bp_hold[%0d] got=%b exp=0011", i, a.gray); end
      vectors++; if (a.stall !== 1'b1) begin miscompares++; $display("FAIL bp_stall[%0d] got=%b exp=1", i, a.stall); end
    end
    out_ready = 1'b1; #1;
    vectors++; if (a.stall !== 1'b0) begin miscompares++; $display("FAIL bp_unstall got=%b exp=0", a.stall); end
    tick();
    vectors++; if (a.gray !== 4'b0010) begin miscompares++; $display("FAIL bp_release got=%b exp=0010", a.gray); end
  endtask

  task automatic test_saturate();
    drive(0, 0, 1, 4'b0000, 1); tick();
    vectors++; if (b.out_valid !== 1'b1 || b.gray !== 4'b0000) begin miscompares++;
      $display("FAIL sat_load got=%b/%b exp=1/0000", b.out_valid, b.gray); end
    vectors++; if (b.tc !== 1'b1) begin miscompares++; $display("FAIL sat_tc0 got=%b exp=1", b.tc); end
    drive(1, 0, 0, '0, 1);
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++; if (b.gray !== 4'b0000) begin miscompares++; $display("FAIL sat_gray[%0d] got=%b exp=0000", i, b.gray); end
      vectors++; if (b.out_valid !== 1'b0) begin miscompares++; $display("FAIL sat_valid[%0d] got=%b exp=0", i, b.out_valid); end
      vectors++; if (b.tc !== 1'b1) begin miscompares++; $display("FAIL sat_tc[%0d] got=%b exp=1", i, b.tc); end
    end
    // Wrapping instance moved 0 -> 15 -> 14 meanwhile.
    vectors++; if (a.gray !== 4'b1001) begin miscompares++; $display("FAIL wrap_dn got=%b exp=1001", a.gray); end
  endtask

  task automatic test_load_stall();
    drive(0, 1, 1, 4'd3, 0); tick();
    vectors++; if (a.stall !== 1'b1) begin miscompares++; $display("FAIL ls_stall got=%b exp=1", a.stall); end
    drive(0, 1, 1, 4'b1010, 0); tick();
    vectors++; if (a.gray !== 4'b1111) begin miscompares++; $display("FAIL ls_gray got=%b exp=1111", a.gray); end
    vectors++; if (a.out_valid !== 1'b1) begin miscompares++; $display("FAIL ls_valid got=%b exp=1", a.out_valid); end
  endtask

  task automatic test_async_reset();
    drive(0, 1, 1, 4'd4, 1); tick();
    vectors++; if (a.gray !== 4'b0110) begin miscompares++; $display("FAIL ar_pre got=%b exp=0110", a.gray); end
    drive(1, 1, 0, '0, 1);
    @(negedge clk); rst_n = 1'b0; model_reset(); #1;
    vectors++; if (a.gray !== 4'b0000 || a.out_valid !== 1'b0) begin miscompares++;
      $display("FAIL ar_clear got=%b/%b exp=0000/0", a.gray, a.out_valid); end
`ifdef GRAY_CNT_SRC_PARITY_EN
    vectors++; if (a.gray_par !== 1'b0 || a.step_err !== 1'b0) begin miscompares++;
      $display("FAIL ar_par got=%b%b exp=00", a.gray_par, a.step_err); end
`endif
    @(negedge clk); rst_n = 1'b1;
    tick();
    vectors++; if (a.gray !== 4'b0001) begin miscompares++; $display("FAIL ar_first got=%b exp=0001", a.gray); end
  endtask

  task automatic test_random();
    logic [W-1:0] g, prev;
    logic         v, s, t;
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(3) != 0), 1'($urandom), ($urandom_range(7) == 0),
            W'($urandom), ($urandom_range(9) < 7));
      #1;
      for (int i = 0; i < 2; i++) begin
        s = (i == 0) ? a.stall : b.stall;
        t = (i == 0) ? a.tc : b.tc;
        vectors++; if (s !== (m_vld[i] & ~out_ready)) begin miscompares++;
          $display("FAIL rnd_stall[%0d/%0d] got=%b exp=%b", n, i, s, m_vld[i] & ~out_ready); end
        vectors++; if (t !== (up_dn ? (m_cnt[i] == MAX) : (m_cnt[i] == 0))) begin miscompares++;
          $display("FAIL rnd_tc[%0d/%0d] got=%b cnt=%0d up=%b", n, i, t, m_cnt[i], up_dn); end
      end
      prev = a.gray;
      tick();
      for (int i = 0; i < 2; i++) begin
        g = (i == 0) ? a.gray : b.gray;
        v = (i == 0) ? a.out_valid : b.out_valid;
        vectors++; if (gray2bin(GRAY_FN_W'(g)) !== GRAY_FN_W'(m_cnt[i])) begin miscompares++;
          $display("FAIL rnd_cnt[%0d/%0d] got=%0d exp=%0d", n, i, gray2bin(GRAY_FN_W'(g)), m_cnt[i]); end
        vectors++; if (v !== m_vld[i]) begin miscompares++;
          $display("FAIL rnd_valid[%0d/%0d] got=%b exp=%b", n, i, v, m_vld[i]); end
      end
      if (!load && a.gray != prev) begin
        vectors++; if ($countones(a.gray ^ prev) != 1) begin miscompares++;
          $display("FAIL rnd_hamming[%0d] got=%b prev=%b", n, a.gray, prev); end
      end
`ifdef GRAY_CNT_SRC_PARITY_EN
      vectors++; if (a.gray_par !== ^a.gray || a.step_err !== 1'b0) begin miscompares++;
        $display("FAIL rnd_par[%0d] got=%b%b exp=%b0", n, a.gray_par, a.step_err, ^a.gray); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_wrap();
    test_backpressure();
    test_saturate();
    test_load_stall();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gray_cnt_src.md
Name: gray_cnt_src

Overview:
- Registered Gray-code up/down counter with binary load and a valid/ready output handshake.
- Sits directly upstream of the 4-bit Gray-to-binary converter and produces the Gray words it consumes.
- Only one output bit changes per step, so the Gray bus is safe to sample across a clock-domain boundary.

Parameters:
- WIDTH, 4, counter and Gray bus width (legal range >= 2).
- WRAP, 1. 1 = modulo wrap at the ends; 0 = saturate at all-ones (up) or zero (down).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  step request. Sampled only on edges where the output slot is free.
- up_dn  input  1  direction: 1 = up, 0 = down.
- load  input  1  load request, highest priority.
- load_bin  input  WIDTH  binary value to load.
- out_ready  input  1  downstream accepts the current word.
- gray  output  WIDTH  registered Gray code of the internal binary count.
- out_valid  output  1  gray holds a word not yet accepted.
- stall  output  1  combinational: out_valid & ~out_ready.
- tc  output  1  combinational terminal count: up_dn ? (bin_q == all-ones) : (bin_q == 0).

Behaviour:
- State: binary register bin_q[WIDTH], register gray_q, flag out_valid. gray = gray_q.
- Reset (rst_n = 0, asynchronous, no clock needed): bin_q = 0, gray = 0, out_valid = 0. Consequently stall = 0 and tc = ~up_dn.
- Slot free: free = ~out_valid | out_ready.
- Priority at each rising edge:
  1. load = 1: bin_q <= load_bin, gray_q <= load_bin ^ (load_bin >> 1), out_valid <= 1. Accepted even while stalled; overwrites a pending word. The overwritten word is lost by design.
  2. Else en & free & step-legal: bin_q <= bin_q ± 1 (mod 2^WIDTH), gray_q <= Gray(next), out_valid <= 1.
  3. Else if out_valid & out_ready: out_valid <= 0; count unchanged.
  4. Else hold everything.
- Step-legal is always 1 when WRAP = 1. When WRAP = 0 it equals ~tc: a saturated step is no step, so no new valid and the count holds.
- Wrap (WRAP = 1): up from all-ones goes to 0; down from 0 goes to all-ones. gray changes in the MSB only.
- Latency: a step or load decided at edge k appears on gray and out_valid after edge k (one cycle).
- Back-to-back: with out_ready held at 1 and en held at 1, one step per clock and out_valid stays 1.
- en asserted while stalled has no effect and is not queued. Upstream holds en until stall drops.
- Every accepted step changes exactly one bit of gray (Hamming distance 1).
- A direction change between steps is legal. The next step uses the new direction.
- Reset asserted mid-operation clears state immediately. The first step after release starts from 0.

Optional Feature:
- Macro: GRAY_CNT_SRC_PARITY_EN.
- Defined:
  - Adds output gray_par (1 bit, registered), updated with gray_q to XOR(gray_q next value); reset value 0.
  - Adds output step_err (1 bit, registered): set when an accepted step changes other than exactly one gray bit. Sticky until reset.
  - gray_par toggles on every accepted single step.
- Undefined: neither port exists, and logic is otherwise identical.

Decomposition:
- Package gray_pkg holds:
  - DEFAULT_GRAY_WIDTH = 4.
  - Functions bin2gray(b) = b ^ (b >> 1) and gray2bin(g) (prefix XOR from MSB).
  - The benches reuse gray2bin as the reference model for the downstream converter.
- No sub-module. All logic is one always block for state plus continuous assigns for stall and tc.

Test Plan:
- Reset, then en = 1, up_dn = 1, out_ready = 1 for 5 clocks -> gray = 0001, 0011, 0010, 0110, 0111; out_valid = 1 from the first edge. Downstream reads binary 1..5.
- WRAP = 1: load 1111 -> gray 1000 with tc = 1. Next up step -> gray 0000, tc = 0.
- Backpressure: after gray = 0011, hold out_ready = 0 with en = 1 for 3 clocks -> gray holds 0011, stall = 1. Raise out_ready -> 0010 on the next edge.
- WRAP = 0, up_dn = 0, load 0000, en = 1, out_ready = 1 -> first edge accepts the word. Then gray stays 0000 and out_valid drops to 0. tc = 1 throughout.
- Load during stall: out_valid = 1, out_ready = 0, load = 1, load_bin = 1010 -> gray = 1111 and out_valid = 1 after the edge.
- Async reset asserted between edges mid-count (gray = 0110) -> gray = 0000 and out_valid = 0 before the next edge. With GRAY_CNT_SRC_PARITY_EN, gray_par = 0 and step_err = 0 throughout.
